// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default oversampling ratio shared by the UART transmitter and receiver.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int OS = 16;
endpackage

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: pops bytes from the tx FIFO and serialises them LSB first onto tx, paced by s_tick.
module uart_tx_fifo_reader #(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int OS = uart_pkg::OS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            en,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);
  import uart_pkg::*;
  localparam int SW = $clog2(OS > SB_TICK ? OS : SB_TICK);
  localparam int NW = $clog2(DBIT);
  state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic tx_q, tx_d;
  logic fetch;
  // rst gates the fetch so an IDLE state held by reset never pops the FIFO
  assign fetch = en & ~fifo_empty & ~rst;
  assign tx = tx_q;
  assign busy = state_q != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      s_q <= '0;
      n_q <= '0;
      b_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      n_q <= n_d;
      b_q <= b_d;
      tx_q <= tx_d;
    end
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    n_d = n_q;
    b_d = b_q;
    tx_d = 1'b1;
    fifo_rd = 1'b0;
    tx_done_tick = 1'b0;
    case (state_q)
      IDLE: if (fetch) begin
        fifo_rd = 1'b1;
        b_d = fifo_r_data;
        s_d = '0;
        state_d = START;
      end
      START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          s_d = s_q == SW'(OS - 1) ? '0 : s_q + 1'b1;
          if (s_q == SW'(OS - 1)) begin
            n_d = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        tx_d = b_q[0];
        if (s_tick) begin
          s_d = s_q == SW'(OS - 1) ? '0 : s_q + 1'b1;
          if (s_q == SW'(OS - 1)) begin
            b_d = b_q >> 1;
            n_d = n_q == NW'(DBIT - 1) ? n_q : n_q + 1'b1;
            state_d = n_q == NW'(DBIT - 1) ? STOP : DATA;
          end
        end
      end
      default: if (s_tick) begin
        s_d = s_q == SW'(SB_TICK - 1) ? '0 : s_q + 1'b1;
        // last stop tick doubles as the fetch slot so queued bytes go out with no idle gap
        if (s_q == SW'(SB_TICK - 1)) begin
          tx_done_tick = 1'b1;
          fifo_rd = fetch;
          b_d = fetch ? fifo_r_data : b_q;
          state_d = fetch ? START : IDLE;
        end
      end
    endcase
  end
endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
- Read-side consumer of the transmit FIFO. It pops bytes from the FIFO through the FIFO's empty/rd handshake and serialises each byte onto the UART tx line, LSB first: one start bit, DBIT data bits, then the stop period.
- Bit timing comes from an external oversampling baud tick (s_tick). This block generates no baud rate itself.
- Sits between the FIFO (empty, read data) and the tx pad.

Parameters:
- DBIT, 8: data bits per frame (5..8).
- SB_TICK, 16: s_tick count for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- OS, 16: s_ticks per data/start bit (oversampling ratio).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- s_tick  in  1  one-clk pulse, OS per bit period.
- en  in  1  transmit enable; sampled only at frame boundaries.
- fifo_empty  in  1  FIFO empty flag.
- fifo_r_data  in  DBIT  FIFO head word; valid whenever fifo_empty=0 (asynchronous read of the register file).
- fifo_rd  out  1  one-clk pop strobe to the FIFO.
- tx  out  1  serial line; registered.
- busy  out  1  high while a frame is in progress (state != IDLE).
- tx_done_tick  out  1  one-clk pulse at the end of each frame's stop period.

Behaviour:
- Reset values: state=IDLE, tx=1, fifo_rd=0, busy=0, tx_done_tick=0, tick counter s=0, bit counter n=0, shift register=0.
- Reset asserted mid-frame: all of the above take effect immediately; the line returns to idle-high; no pop; the partial frame is abandoned.
- Registers:
  - s: width clog2(max(OS, SB_TICK)).
  - n: width clog2(DBIT).
  - b: shift register, DBIT bits.
  - tx_reg.
- tx = tx_reg. tx_reg <= tx_next every clk, so tx lags the state by one clk and is glitch-free.
- Frame fetch (IDLE, or the last STOP tick):
  - Condition: en=1 and fifo_empty=0.
  - Same clk: b <= fifo_r_data; fifo_rd=1 for exactly that clk; s <= 0; next state START.
  - fifo_rd is combinational from state and inputs. It is never asserted while fifo_empty=1, and never more than once per frame.
- IDLE: tx_next=1. If the fetch condition fails, stay in IDLE.
- START:
  - tx_next=0.
  - On s_tick: if s==OS-1, then s<=0, n<=0, go to DATA; else s<=s+1.
- DATA:
  - tx_next=b[0].
  - On s_tick with s==OS-1: s<=0; b<=b>>1.
  - Then, if n==DBIT-1, go to STOP; else n<=n+1.
  - On s_tick otherwise: s<=s+1.
- STOP:
  - tx_next=1.
  - On s_tick with s==SB_TICK-1: tx_done_tick=1 for that clk.
  - In that same clk, if the fetch condition holds, fetch and go straight to START (back-to-back, zero idle gap). Otherwise go to IDLE.
  - On s_tick otherwise: s<=s+1.
- No s_tick: s, n and state hold. The only exception is the IDLE fetch, which does not wait for s_tick.
- en deasserted mid-frame: the current frame completes normally; no further fetch.
- Frame length: exactly 1+DBIT bit periods of OS ticks, plus SB_TICK ticks. Start-bit alignment to s_tick may vary by up to one tick period after an IDLE fetch.
- fifo_empty rising while busy has no effect on the current frame, because data is already latched in b.

Decomposition:
- Package uart_pkg:
  - state typedef enum logic[1:0] {IDLE, START, DATA, STOP};
  - localparam OS default 16.
  - Shared with the receiver.
- Single module; no sub-module. The baud tick generator and the FIFO (register file plus pointer control) are separate existing blocks, instantiated alongside this one at the UART top level.

Test Plan:
All scenarios use DBIT=8, SB_TICK=16, s_tick every 4 clk (bit = 64 clk) unless stated otherwise.
- FIFO holds 0x55, en=1 -> exactly 1 fifo_rd pulse. tx = 0,1,0,1,0,1,0,1,0 (start plus LSB-first data), each 64 clk, then 1 for 64 clk. tx_done_tick once. busy falls after that.
- FIFO holds 0xA5, 0x3C -> 2 fifo_rd pulses. The second start bit begins on the clk after the first stop's last tick (no idle gap). Data bits are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0. 2 tx_done_ticks.
- fifo_empty=1 permanently, en=1 for 1000 clk -> tx=1, fifo_rd=0, busy=0 throughout.
- en dropped during DATA of the first of two queued bytes -> the first frame completes bit-exact; no second fifo_rd; tx stays 1.
- rst pulsed during DATA bit 3 -> tx=1 the same cycle; state IDLE; no fifo_rd while rst is high. After release, the remaining FIFO byte is sent as a full, correct frame.
- SB_TICK=32, byte 0xFF -> start 64 clk low, data 512 clk high, stop 128 clk high; tx_done_tick at 704 clk after the start edge.
